// File: rtl/data_proc_core.sv
// Pixel processing core: input FIFO, per-pixel compute, registered valid/ready output
// and a job FSM tracking accepted and delivered pixel counts.
module data_proc_core #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_mode,
  input  logic [PIX_W-1:0] ctrl_param,
  input  logic [CNT_W-1:0] ctrl_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pix_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [PIX_W-1:0]   param_q, param_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic [PIX_W-1:0]   od_q, od_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PIX_W-1:0]   mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop, start_ok;

  function automatic logic [PIX_W-1:0] compute(input logic [1:0]       mode,
                                               input logic [PIX_W-1:0] p,
                                               input logic [PIX_W-1:0] k);
    logic [PIX_W:0]   sum;
    logic [PIX_W-1:0] res;
    sum = {1'b0, p} + {1'b0, k};
    res = p;
    case (mode)
      2'b00:   res = p;
      2'b01:   res = ~p;
      2'b10:   res = (p >= k) ? '1 : '0;
      default: res = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
    endcase
    return res;
  endfunction

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready  = (state_q == StRun) && !fifo_full && (acc_q < len_q);
  assign push      = in_valid && in_ready;
  assign pop       = !fifo_empty && (!ov_q || out_ready);
  assign start_ok  = ctrl_start && ((state_q == StIdle) || (state_q == StDone));

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign pix_count = cnt_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    param_d  = param_q;
    len_d    = len_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    od_d     = od_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      acc_d    = acc_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      ov_d     = 1'b1;
      od_d     = compute(mode_q, mem_q[rd_ptr_q[AW-1:0]], param_q);
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
    if (ov_q && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          mode_d  = ctrl_mode;
          param_d = ctrl_param;
          len_d   = ctrl_len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (ctrl_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (push && ((acc_q + CNT_W'(1)) == len_q)) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && !ov_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= 2'b00;
      param_q  <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      param_q  <= param_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule
